mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port, registered-read data RAM between two requesters: the CPU (read/write) and the video scan-out reader (read-only).
- Sits between the requesters and the RAM block. It drives the RAM's en/memwrite/memread/adr/writedata and routes the returned memdata back to the correct requester.
- Video has priority for real-time scan-out. A streak counter bounds CPU starvation.

Parameters:
- WIDTH, 16, data word width.
- RAM_ADDR_BITS, 16, RAM address width.
- MAX_VID_STREAK, 4, max consecutive video grants while CPU waits (range 1..15).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_adr  in  RAM_ADDR_BITS  CPU address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rdata  out  WIDTH  CPU read data; holds last value.
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata fresh.
- vid_req  in  1  video read request.
- vid_adr  in  RAM_ADDR_BITS  video address.
- vid_gnt  out  1  video access accepted this cycle.
- vid_rdata  out  WIDTH  video read data; holds last value.
- vid_rvalid  out  1  one-cycle pulse, vid_rdata fresh.
- mem_en  out  1  RAM enable.
- mem_write  out  1  RAM write strobe.
- mem_read  out  1  RAM read strobe.
- mem_adr  out  RAM_ADDR_BITS  RAM address.
- mem_wdata  out  WIDTH  RAM write data.
- mem_rdata  in  WIDTH  RAM registered read data.

Behaviour:
- Reset (async, while reset=1):
  - cpu_gnt = vid_gnt = 0; mem_en/mem_write/mem_read = 0; mem_adr = 0; mem_wdata = 0.
  - cpu_rvalid = vid_rvalid = 0; cpu_rdata = vid_rdata = 0; streak = 0.
  - Both pipeline tags = NONE.
- Arbitration is combinational within the cycle; at most one grant per cycle.
  - Only one requester asserting: that requester wins.
  - Both requesting: video wins unless streak == MAX_VID_STREAK, in which case the CPU wins.
- Streak counter (4-bit, registered):
  - Increments on each video grant while cpu_req=1.
  - Clears on any CPU grant, or on any cycle with cpu_req=0.
  - Saturates at MAX_VID_STREAK; never wraps.
- Memory drive in grant cycle T:
  - mem_en = 1; mem_adr = winner address.
  - CPU write: mem_write = 1, mem_read = 0, mem_wdata = cpu_wdata.
  - Any read: mem_read = 1, mem_write = 0.
  - No grant: mem_en = mem_write = mem_read = 0; mem_adr and mem_wdata hold their previous value.
- Read return pipeline:
  - Stage 1 tag (NONE/CPU/VID) is registered at the end of T. The RAM presents mem_rdata during T+1.
  - Stage 2 registers mem_rdata into the owner's rdata register at the end of T+1.
  - The owner's rvalid is high during T+2 only. Grant-to-rvalid latency is exactly 2 cycles.
- Writes produce no rvalid; the write is committed at the end of T.
- Back-to-back grants every cycle are supported with full throughput. Tags pipeline independently.
- A requester may drop req after gnt. Holding req issues a new access each cycle it wins.
- CPU read after CPU write to the same address in consecutive grants returns the new data (RAM write precedes the later read edge).
- rdata registers update only on their own rvalid. The other requester's register is unaffected.
- Reset mid-operation: in-flight tags are cleared, no rvalid is produced after reset deasserts, and rdata registers return to 0.

Decomposition:
- Package mem_arb_pkg:
  - Owner tag constants OWNER_NONE = 2'd0, OWNER_CPU = 2'd1, OWNER_VID = 2'd2.
  - Default MAX_VID_STREAK.
- One natural sub-module, mem_arb_rtn: the 2-stage tag/data return pipeline producing the rdata/rvalid pairs.
- Arbitration and the streak counter stay in mem_arbiter.

Test Plan:
- CPU write 0x1234 to 0x0010, then CPU read 0x0010 → cpu_gnt both cycles; cpu_rvalid 2 cycles after the read grant with cpu_rdata = 0x1234; vid_rvalid stays 0.
- vid_req and cpu_req held continuously, MAX_VID_STREAK = 4 → grant sequence V,V,V,V,C,V,V,V,V,C; streak never exceeds 4.
- Video reads 0x0100..0x0103 back-to-back (RAM preloaded 0xA0..0xA3) → vid_rvalid high 4 consecutive cycles starting 2 cycles after first grant, data 0xA0..0xA3 in order.
- Interleaved V read 0x0001 (0x1111) then C read 0x0002 (0x2222) on consecutive cycles → vid_rvalid at T+2 with 0x1111, cpu_rvalid at T+3 with 0x2222; each rdata holds afterwards.
- Reset asserted 1 cycle after a CPU read grant → no cpu_rvalid ever appears; cpu_rdata = 0; mem_en = 0 while in reset.
- No requests for 10 cycles → mem_en = 0, both gnt = 0, streak = 0, no rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the RAM arbiter: pipeline owner tags and the default
// video starvation bound.
package mem_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWNER_NONE = 2'd0;
    localparam owner_t OWNER_CPU  = 2'd1;
    localparam owner_t OWNER_VID  = 2'd2;

    localparam int DEFAULT_MAX_VID_STREAK = 4;

endpackage

// File: rtl/mem_arb_rtn.sv
// Two-stage read return path: tags each read at issue, then steers the RAM's
// registered output into the owning requester's data register.
module mem_arb_rtn
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  owner_t           issue_tag,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] vid_rdata,
    output logic             vid_rvalid
);

    owner_t tag_q;

    // tag_q names the owner of the word the RAM is presenting this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q      <= OWNER_NONE;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            vid_rdata  <= '0;
            vid_rvalid <= 1'b0;
        end else begin
            tag_q      <= issue_tag;
            cpu_rvalid <= (tag_q == OWNER_CPU);
            vid_rvalid <= (tag_q == OWNER_VID);
            if (tag_q == OWNER_CPU) begin
                cpu_rdata <= mem_rdata;
            end
            if (tag_q == OWNER_VID) begin
                vid_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data RAM between the CPU and the video scan-out reader.
// Video has priority; a streak counter guarantees the CPU eventually gets in.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int RAM_ADDR_BITS  = 16,
    parameter int MAX_VID_STREAK = DEFAULT_MAX_VID_STREAK
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [RAM_ADDR_BITS-1:0] cpu_adr,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic                     cpu_gnt,
    output logic [WIDTH-1:0]         cpu_rdata,
    output logic                     cpu_rvalid,
    input  logic                     vid_req,
    input  logic [RAM_ADDR_BITS-1:0] vid_adr,
    output logic                     vid_gnt,
    output logic [WIDTH-1:0]         vid_rdata,
    output logic                     vid_rvalid,
    output logic                     mem_en,
    output logic                     mem_write,
    output logic                     mem_read,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_VID_STREAK);

    logic [3:0]               streak;
    logic                     cpu_win;
    logic                     vid_win;
    logic [RAM_ADDR_BITS-1:0] adr_q;
    logic [WIDTH-1:0]         wdata_q;
    owner_t                   issue_tag;

    // Video wins a contested cycle unless it has already starved the CPU for
    // the maximum streak; nothing is granted while reset is held.
    always_comb begin
        cpu_win = 1'b0;
        vid_win = 1'b0;
        if (!reset) begin
            if (vid_req && (!cpu_req || streak != STREAK_MAX)) begin
                vid_win = 1'b1;
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end
        end
    end

    assign cpu_gnt   = cpu_win;
    assign vid_gnt   = vid_win;
    assign mem_en    = cpu_win | vid_win;
    assign mem_write = cpu_win & cpu_we;
    assign mem_read  = vid_win | (cpu_win & ~cpu_we);

    always_comb begin
        mem_adr   = adr_q;
        mem_wdata = wdata_q;
        issue_tag = OWNER_NONE;
        if (cpu_win) begin
            mem_adr = cpu_adr;
            if (cpu_we) begin
                mem_wdata = cpu_wdata;
            end else begin
                issue_tag = OWNER_CPU;
            end
        end else if (vid_win) begin
            mem_adr   = vid_adr;
            issue_tag = OWNER_VID;
        end
    end

    // Idle cycles leave the RAM bus parked on the last granted address/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            if (mem_en) begin
                adr_q <= mem_adr;
            end
            if (mem_write) begin
                wdata_q <= mem_wdata;
            end
        end
    end

    // Counts video grants that made a waiting CPU wait longer; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= 4'd0;
        end else if (!cpu_req || cpu_win) begin
            streak <= 4'd0;
        end else if (vid_win && streak != STREAK_MAX) begin
            streak <= streak + 4'd1;
        end
    end

    mem_arb_rtn #(
        .WIDTH(WIDTH)
    ) u_rtn (
        .clk       (clk),
        .reset     (reset),
        .issue_tag (issue_tag),
        .mem_rdata (mem_rdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .vid_rdata (vid_rdata),
        .vid_rvalid(vid_rvalid)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read RAM
// attached to the memory port.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_adr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        vid_req;
    logic [15:0] vid_adr;
    logic        vid_gnt;
    logic [15:0] vid_rdata;
    logic        vid_rvalid;
    logic        mem_en;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_adr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        preloadEn;
    logic [15:0] preloadAdr;
    logic [15:0] preloadData;
    logic [15:0] ram [0:65535];

    int assertCount;
    int failCount;

    mem_arbiter #(
        .WIDTH(16),
        .RAM_ADDR_BITS(16),
        .MAX_VID_STREAK(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .vid_req   (vid_req),
        .vid_adr   (vid_adr),
        .vid_gnt   (vid_gnt),
        .vid_rdata (vid_rdata),
        .vid_rvalid(vid_rvalid),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM with registered read; the preload port is a bench backdoor.
    always @(posedge clk) begin
        if (preloadEn) begin
            ram[preloadAdr] <= preloadData;
        end else if (mem_en) begin
            if (mem_write) begin
                ram[mem_adr] <= mem_wdata;
            end
            if (mem_read) begin
                mem_rdata <= ram[mem_adr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [15:0] cAdr,
                                 input logic [15:0] cWdata, input logic vReq, input logic [15:0] vAdr);
        cpu_req   = cReq;
        cpu_we    = cWe;
        cpu_adr   = cAdr;
        cpu_wdata = cWdata;
        vid_req   = vReq;
        vid_adr   = vAdr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", name, observed, expected);
        end
    endtask

    task automatic preload(input logic [15:0] adr, input logic [15:0] data);
        preloadEn   = 1'b1;
        preloadAdr  = adr;
        preloadData = data;
        tick();
        preloadEn = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        preloadEn   = 1'b0;
        preloadAdr  = '0;
        preloadData = '0;
        mem_rdata   = '0;
        reset       = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

        // Reset state, with RAM preloaded while reset is held.
        preload(16'h0100, 16'h00A0);
        preload(16'h0101, 16'h00A1);
        preload(16'h0102, 16'h00A2);
        preload(16'h0103, 16'h00A3);
        preload(16'h0001, 16'h1111);
        preload(16'h0002, 16'h2222);
        applyStimulus(1'b1, 1'b1, 16'h0055, 16'hBEEF, 1'b1, 16'h0066);
        checkOutput("rst_cpu_gnt", 16'(cpu_gnt), 16'd0);
        checkOutput("rst_vid_gnt", 16'(vid_gnt), 16'd0);
        checkOutput("rst_mem_en", 16'(mem_en), 16'd0);
        checkOutput("rst_mem_write", 16'(mem_write), 16'd0);
        checkOutput("rst_mem_read", 16'(mem_read), 16'd0);
        checkOutput("rst_mem_adr", mem_adr, 16'h0000);
        checkOutput("rst_mem_wdata", mem_wdata, 16'h0000);
        checkOutput("rst_cpu_rvalid", 16'(cpu_rvalid), 16'd0);
        checkOutput("rst_vid_rvalid", 16'(vid_rvalid), 16'd0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 16'h0000);
        checkOutput("rst_vid_rdata", vid_rdata, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] CPU write then read of 0x0010");
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0);
        checkOutput("wr_cpu_gnt", 16'(cpu_gnt), 16'd1);
        checkOutput("wr_vid_gnt", 16'(vid_gnt), 16'd0);
        checkOutput("wr_mem_en", 16'(mem_en), 16'd1);
        checkOutput("wr_mem_write", 16'(mem_write), 16'd1);
        checkOutput("wr_mem_read", 16'(mem_read), 16'd0);
        checkOutput("wr_mem_adr", mem_adr, 16'h0010);
        checkOutput("wr_mem_wdata", mem_wdata, 16'h1234);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0);
        checkOutput("rd_cpu_gnt", 16'(cpu_gnt), 16'd1);
        checkOutput("rd_mem_read", 16'(mem_read), 16'd1);
        checkOutput("rd_mem_write", 16'(mem_write), 16'd0);
        checkOutput("rd_mem_adr", mem_adr, 16'h0010);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        checkOutput("idle_mem_en", 16'(mem_en), 16'd0);
        checkOutput("idle_mem_adr_hold", mem_adr, 16'h0010);
        checkOutput("idle_mem_wdata_hold", mem_wdata, 16'h1234);
        checkOutput("wr_no_rvalid", 16'(cpu_rvalid), 16'd0);
        tick();
        checkOutput("rd_cpu_rvalid", 16'(cpu_rvalid), 16'd1);
        checkOutput("rd_cpu_rdata", cpu_rdata, 16'h1234);
        checkOutput("rd_vid_rvalid", 16'(vid_rvalid), 16'd0);
        tick();
        checkOutput("rd_rvalid_pulse", 16'(cpu_rvalid), 16'd0);
        checkOutput("rd_rdata_hold", cpu_rdata, 16'h1234);
        tick();

        $display("[TB] Contested requests, streak bound 4");
        begin
            logic [9:0] vidSeq;
            vidSeq = 10'b0111101111;
            for (int i = 0; i < 10; i++) begin
                applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0, 1'b1, 16'h0200);
                checkOutput($sformatf("streak_%0d", i), 16'(dut.streak), 16'(i % 5));
                checkOutput($sformatf("arb_vid_gnt_%0d", i), 16'(vid_gnt), 16'(vidSeq[i]));
                checkOutput($sformatf("arb_cpu_gnt_%0d", i), 16'(cpu_gnt), 16'(!vidSeq[i]));
                tick();
            end
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        repeat (3) tick();

        $display("[TB] Video burst 0x0100..0x0103");
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'(16'h0100 + i));
                checkOutput($sformatf("burst_gnt_%0d", i), 16'(vid_gnt), 16'd1);
            end else begin
                applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            end
            checkOutput($sformatf("burst_rvalid_%0d", i), 16'(vid_rvalid), 16'((i >= 2) && (i <= 5)));
            if (i >= 2 && i <= 5) begin
                checkOutput($sformatf("burst_rdata_%0d", i), vid_rdata, 16'(16'h00A0 + i - 2));
            end
            tick();
        end
        tick();

        $display("[TB] Interleaved video then CPU reads");
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0001);
        checkOutput("il_vid_gnt", 16'(vid_gnt), 16'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, 16'h0);
        checkOutput("il_cpu_gnt", 16'(cpu_gnt), 16'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        checkOutput("il_vid_rvalid", 16'(vid_rvalid), 16'd1);
        checkOutput("il_vid_rdata", vid_rdata, 16'h1111);
        checkOutput("il_cpu_rvalid_early", 16'(cpu_rvalid), 16'd0);
        tick();
        checkOutput("il_cpu_rvalid", 16'(cpu_rvalid), 16'd1);
        checkOutput("il_cpu_rdata", cpu_rdata, 16'h2222);
        checkOutput("il_vid_rvalid_pulse", 16'(vid_rvalid), 16'd0);
        checkOutput("il_vid_rdata_hold", vid_rdata, 16'h1111);
        tick();
        checkOutput("il_cpu_rvalid_pulse", 16'(cpu_rvalid), 16'd0);
        checkOutput("il_cpu_rdata_hold", cpu_rdata, 16'h2222);
        checkOutput("il_vid_rdata_hold2", vid_rdata, 16'h1111);
        tick();

        $display("[TB] Reset during an in-flight CPU read");
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0);
        checkOutput("mr_cpu_gnt", 16'(cpu_gnt), 16'd1);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("mr_cpu_gnt_in_reset", 16'(cpu_gnt), 16'd0);
        checkOutput("mr_mem_en_in_reset", 16'(mem_en), 16'd0);
        checkOutput("mr_mem_adr_in_reset", mem_adr, 16'h0000);
        checkOutput("mr_cpu_rdata_cleared", cpu_rdata, 16'h0000);
        checkOutput("mr_vid_rdata_cleared", vid_rdata, 16'h0000);
        tick();
        checkOutput("mr_cpu_rvalid_in_reset", 16'(cpu_rvalid), 16'd0);
        checkOutput("mr_mem_en_in_reset2", 16'(mem_en), 16'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("mr_no_rvalid_%0d", i), 16'(cpu_rvalid), 16'd0);
            checkOutput($sformatf("mr_rdata_zero_%0d", i), cpu_rdata, 16'h0000);
            tick();
        end

        $display("[TB] Ten idle cycles");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            checkOutput($sformatf("idle_en_%0d", i), 16'(mem_en), 16'd0);
            checkOutput($sformatf("idle_gnt_%0d", i), 16'({cpu_gnt, vid_gnt}), 16'd0);
            checkOutput($sformatf("idle_rvalid_%0d", i), 16'({cpu_rvalid, vid_rvalid}), 16'd0);
            checkOutput($sformatf("idle_streak_%0d", i), 16'(dut.streak), 16'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
